// File: rtl/mandelbrot_pixel_scheduler.sv
// rtl/mandelbrot_pixel_scheduler.sv - raster-scan pixel dispatch to N iteration cores, round-robin result merge
module mandelbrot_pixel_scheduler #(
    parameter int WIDTH   = 27,
    parameter int FBITS   = 22,
    parameter int MAX_H   = 640,
    parameter int MAX_V   = 480,
    parameter int N_CORES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       re_start,
    input  logic [WIDTH-1:0]       im_start,
    input  logic [WIDTH-1:0]       re_step,
    input  logic [WIDTH-1:0]       im_step,
    input  logic [N_CORES-1:0]     core_idle,
    output logic [N_CORES-1:0]     core_start,
    output logic [9:0]             core_req_x,
    output logic [9:0]             core_req_y,
    output logic [WIDTH-1:0]       core_req_re,
    output logic [WIDTH-1:0]       core_req_im,
    input  logic [N_CORES-1:0]     core_res_valid,
    input  logic [32*N_CORES-1:0]  core_res_data,
    output logic [N_CORES-1:0]     core_res_ack,
    output logic [31:0]            pos_rgb_data,
    output logic                   data_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]   cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic [WIDTH-1:0]   re_start_q, re_start_d, re_step_q, re_step_d, im_step_q, im_step_d;
    logic [PW-1:0]      disp_ptr_q, disp_ptr_d, coll_ptr_q, coll_ptr_d;
    logic [18:0]        outstanding_q, outstanding_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic [PW:0]        grant_sel, src_sel;
    logic               dispatch, acked;

    // Returns {found, index}: lowest requester at or above ptr, else lowest below it.
    function automatic logic [PW:0] rr_search(input logic [N_CORES-1:0] req, input logic [PW-1:0] ptr);
        logic          hi_ok, lo_ok;
        logic [PW-1:0] hi, lo;
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        hi    = '0;
        lo    = '0;
        for (int j = N_CORES - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (PW'(j) >= ptr) begin
                    hi_ok = 1'b1;
                    hi    = PW'(j);
                end else begin
                    lo_ok = 1'b1;
                    lo    = PW'(j);
                end
            end
        end
        return hi_ok ? {1'b1, hi} : {lo_ok, lo};
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        return (idx == PW'(N_CORES - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign grant_sel    = rr_search(core_idle, disp_ptr_q);
    assign src_sel      = rr_search(core_res_valid, coll_ptr_q);
    assign pos_rgb_data = out_data_q;
    assign data_valid   = out_valid_q;
    assign core_req_x   = x_q;
    assign core_req_y   = y_q;
    assign core_req_re  = cur_re_q;
    assign core_req_im  = cur_im_q;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        cur_re_d      = cur_re_q;
        cur_im_d      = cur_im_q;
        re_start_d    = re_start_q;
        re_step_d     = re_step_q;
        im_step_d     = im_step_q;
        disp_ptr_d    = disp_ptr_q;
        coll_ptr_d    = coll_ptr_q;
        outstanding_d = outstanding_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        core_start    = '0;
        core_res_ack  = '0;
        dispatch      = 1'b0;
        acked         = 1'b0;
        busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
        done          = (state_q == S_DONE);

        // Output register refills whenever it is empty or being drained this cycle.
        if (busy && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b0;
            if (src_sel[PW]) begin
                acked       = 1'b1;
                out_valid_d = 1'b1;
                coll_ptr_d  = next_ptr(src_sel[PW-1:0]);
                for (int j = 0; j < N_CORES; j++) begin
                    if (PW'(j) == src_sel[PW-1:0]) begin
                        core_res_ack[j] = 1'b1;
                        out_data_d      = core_res_data[32*j +: 32];
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    x_d           = '0;
                    y_d           = '0;
                    cur_re_d      = re_start;
                    cur_im_d      = im_start;
                    re_start_d    = re_start;
                    re_step_d     = re_step;
                    im_step_d     = im_step;
                    disp_ptr_d    = '0;
                    coll_ptr_d    = '0;
                end
            end
            S_RUN: begin
                if (grant_sel[PW]) begin
                    dispatch   = 1'b1;
                    disp_ptr_d = next_ptr(grant_sel[PW-1:0]);
                    for (int j = 0; j < N_CORES; j++) begin
                        if (PW'(j) == grant_sel[PW-1:0]) core_start[j] = 1'b1;
                    end
                    if (x_q == 10'(MAX_H - 1)) begin
                        x_d      = '0;
                        cur_re_d = re_start_q;
                        y_d      = y_q + 10'd1;
                        cur_im_d = cur_im_q - im_step_q;
                        if (y_q == 10'(MAX_V - 1)) state_d = S_DRAIN;
                    end else begin
                        x_d      = x_q + 10'd1;
                        cur_re_d = cur_re_q + re_step_q;
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0 && !out_valid_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (busy) outstanding_d = outstanding_q + 19'(dispatch) - 19'(acked);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cur_re_q      <= '0;
            cur_im_q      <= '0;
            re_start_q    <= '0;
            re_step_q     <= '0;
            im_step_q     <= '0;
            disp_ptr_q    <= '0;
            coll_ptr_q    <= '0;
            outstanding_q <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cur_re_q      <= cur_re_d;
            cur_im_q      <= cur_im_d;
            re_start_q    <= re_start_d;
            re_step_q     <= re_step_d;
            im_step_q     <= im_step_d;
            disp_ptr_q    <= disp_ptr_d;
            coll_ptr_q    <= coll_ptr_d;
            outstanding_q <= outstanding_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// tb/tb_mandelbrot_pixel_scheduler.sv - scoreboard bench for mandelbrot_pixel_scheduler with stub cores
module tb_mandelbrot_pixel_scheduler;
    localparam int W = 27, H = 4, V = 3, N = 4, NPIX = H * V;
    localparam logic [W-1:0] RE_S   = W'(-(2 << 22));
    localparam logic [W-1:0] IM_S   = W'(1 << 22);
    localparam logic [W-1:0] STEP   = W'(1 << 20);
    localparam logic [W-1:0] RE_3_0 = W'(-(2 << 22) + (3 << 20));
    localparam logic [W-1:0] IM_0_1 = W'((1 << 22) - (1 << 20));

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [W-1:0] re_start = '0, im_start = '0, re_step = '0, im_step = '0;
    logic [N-1:0] core_idle, core_start, core_res_valid, core_res_ack;
    logic [9:0]   core_req_x, core_req_y;
    logic [W-1:0] core_req_re, core_req_im;
    logic [32*N-1:0] core_res_data;
    logic [31:0]  pos_rgb_data;
    logic         data_valid, busy, done;

    always #5 clk = ~clk;

    mandelbrot_pixel_scheduler #(.WIDTH(W), .FBITS(22), .MAX_H(H), .MAX_V(V), .N_CORES(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .re_start(re_start), .im_start(im_start), .re_step(re_step), .im_step(im_step),
        .core_idle(core_idle), .core_start(core_start),
        .core_req_x(core_req_x), .core_req_y(core_req_y),
        .core_req_re(core_req_re), .core_req_im(core_req_im),
        .core_res_valid(core_res_valid), .core_res_data(core_res_data), .core_res_ack(core_res_ack),
        .pos_rgb_data(pos_rgb_data), .data_valid(data_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] iter_of(input logic [9:0] x, input logic [9:0] y);
        return 8'(x * 5 + y * 17) ^ 8'h3C;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Stub cores: random latency, result held until acked, optional per-core visibility gate
    logic [N-1:0] st_busy, st_res;
    logic [N-1:0] gate = '1;
    int           st_cnt [N];
    logic [9:0]   st_x [N], st_y [N];
    int           lat_min = 1, lat_max = 7;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st_busy <= '0;
            st_res  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (core_start[i]) begin
                    st_busy[i] <= 1'b1;
                    st_cnt[i]  <= int'($urandom_range(lat_max, lat_min));
                    st_x[i]    <= core_req_x;
                    st_y[i]    <= core_req_y;
                end else if (st_busy[i]) begin
                    if (st_cnt[i] <= 1) begin
                        st_busy[i] <= 1'b0;
                        st_res[i]  <= 1'b1;
                    end else begin
                        st_cnt[i] <= st_cnt[i] - 1;
                    end
                end
                if (core_res_ack[i]) st_res[i] <= 1'b0;
            end
        end
    end

    assign core_idle      = ~st_busy & ~st_res;
    assign core_res_valid = st_res & gate;
    for (genvar i = 0; i < N; i++) begin : g_stub
        assign core_res_data[32*i +: 32] = {4'(i), st_x[i], st_y[i], iter_of(st_x[i], st_y[i])};
    end

    // Reference model and scoreboard
    int          p_m, q_m, disp_cnt, beats, done_cnt, busy_gap, cyc = 0;
    bit          in_frame = 0, coord_test = 0;
    logic [W-1:0] cfg_re_s, cfg_im_s, cfg_re_st, cfg_im_st;
    logic [31:0] exp_q [N][$];
    int          seen [H][V];
    int          ack_log [$], ack_cyc [$];

    always @(negedge clk) begin
        logic [N-1:0] exp_start, exp_ack;
        logic [W-1:0] e_re, e_im;
        logic [9:0]   px, py;
        int           g, s, mx, my, tag;
        logic         ok;
        cyc++;
        if (!rst) begin
            exp_start = '0;
            g = -1;
            if (busy && disp_cnt < NPIX) g = rr_pick(core_idle, p_m);
            if (g >= 0) exp_start[g] = 1'b1;
            chk("core_start", core_start, exp_start);
            if (g >= 0) begin
                mx   = disp_cnt % H;
                my   = disp_cnt / H;
                e_re = cfg_re_s + W'(mx) * cfg_re_st;
                e_im = cfg_im_s - W'(my) * cfg_im_st;
                chk("req_x", core_req_x, mx);
                chk("req_y", core_req_y, my);
                chk("req_re", core_req_re, e_re);
                chk("req_im", core_req_im, e_im);
                if (coord_test && mx == 3 && my == 0) chk("re_3_0", core_req_re, RE_3_0);
                if (coord_test && mx == 0 && my == 1) begin
                    chk("re_0_1", core_req_re, RE_S);
                    chk("im_0_1", core_req_im, IM_0_1);
                end
                exp_q[g].push_back({4'(g), 10'(mx), 10'(my), iter_of(10'(mx), 10'(my))});
                p_m = (g + 1) % N;
                disp_cnt++;
            end
            exp_ack = '0;
            s = -1;
            if (busy && (!data_valid || out_ready)) s = rr_pick(core_res_valid, q_m);
            if (s >= 0) exp_ack[s] = 1'b1;
            chk("res_ack", core_res_ack, exp_ack);
            if (s >= 0) begin
                q_m = (s + 1) % N;
                ack_log.push_back(s);
                ack_cyc.push_back(cyc);
            end
            if (data_valid && out_ready) begin
                tag = int'(pos_rgb_data[31:28]);
                ok  = 1'b0;
                if (tag < N) ok = (exp_q[tag].size() > 0);
                chk("beat_expected", ok, 1'b1);
                if (ok) chk("beat_word", pos_rgb_data, exp_q[tag].pop_front());
                px = pos_rgb_data[27:18];
                py = pos_rgb_data[17:8];
                if (px < H && py < V) seen[px][py]++;
                beats++;
            end
            if (done) begin
                done_cnt++;
                chk("beats_at_done", beats, NPIX);
                in_frame = 0;
            end
            if (in_frame && !busy) busy_gap++;
        end
    end

    task automatic start_frame(input logic [W-1:0] rs, input logic [W-1:0] is,
                               input logic [W-1:0] rst_v, input logic [W-1:0] ist);
        @(posedge clk);
        #1;
        re_start = rs;  im_start = is;  re_step = rst_v;  im_step = ist;
        cfg_re_s = rs;  cfg_im_s = is;  cfg_re_st = rst_v; cfg_im_st = ist;
        p_m = 0; q_m = 0; disp_cnt = 0; beats = 0; done_cnt = 0; busy_gap = 0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        for (int x = 0; x < H; x++) for (int y = 0; y < V; y++) seen[x][y] = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_frame = 1;
    endtask

    task automatic finish_frame(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt > 0, 1'b1);
        repeat (5) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_beats"}, beats, NPIX);
        chk({tag, "_dispatched"}, disp_cnt, NPIX);
        chk({tag, "_busy_gap"}, busy_gap, 0);
        for (int x = 0; x < H; x++)
            for (int y = 0; y < V; y++) chk($sformatf("%s_seen_%0d_%0d", tag, x, y), seen[x][y], 1);
        for (int i = 0; i < N; i++) chk({tag, "_leftover"}, exp_q[i].size(), 0);
    endtask

    initial begin
        int k;
        logic [31:0] held;
        logic [3:0]  order [4];
        order = '{4'd2, 4'd3, 4'd0, 4'd1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_core_start", core_start, '0);
        chk("rst_ack", core_res_ack, '0);
        chk("rst_data", pos_rgb_data, '0);
        chk("rst_req_re", core_req_re, '0);

        // Frame 1: reference coordinates, restart attempt mid-run must be ignored
        coord_test = 1;
        start_frame(RE_S, IM_S, STEP, STEP);
        repeat (4) @(posedge clk);
        #1;
        re_start = W'(12345);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_restart", busy, 1'b1);
        finish_frame("f1");
        coord_test = 0;

        // Frame 2: 20-cycle output stall
        out_ready = 1'b0;
        start_frame(W'(32'h0123456), W'(32'h7654321), W'(32'h0000333), W'(32'h0001111));
        k = 0;
        while (!data_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("bp_first_valid", data_valid, 1'b1);
        held = pos_rgb_data;
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid_held", data_valid, 1'b1);
            chk("bp_data_stable", pos_rgb_data, held);
            chk("bp_no_ack", core_res_ack, '0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        finish_frame("f2");

        // Frame 3: four simultaneous results with collect pointer at 2
        lat_min = 5;
        lat_max = 5;
        gate    = 4'b0011;
        start_frame(W'(32'h1000000), W'(32'h0200000), W'(32'h0000100), W'(32'h0000200));
        k = 0;
        while (beats < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("cont_two_beats", beats, 2);
        @(posedge clk);
        #1 gate = 4'b0000;
        repeat (15) @(posedge clk);
        #1;
        ack_log.delete();
        ack_cyc.delete();
        gate = 4'b1111;
        repeat (6) @(negedge clk);
        chk("cont_ack_count", ack_log.size() >= 4, 1'b1);
        if (ack_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_ack_%0d", i), ack_log[i], order[i]);
                chk($sformatf("cont_ack_cycle_%0d", i), ack_cyc[i] - ack_cyc[0], i);
            end
        end
        finish_frame("f3");
        lat_min = 1;
        lat_max = 7;

        // Frame 4: reset mid-frame, then a clean frame afterwards
        start_frame(RE_S, IM_S, STEP, STEP);
        repeat (8) @(posedge clk);
        #1;
        in_frame = 0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", data_valid, 1'b0);
        chk("midrst_core_start", core_start, '0);
        chk("midrst_ack", core_res_ack, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_idle", busy, 1'b0);
        end
        start_frame(W'(32'h7FFFF00), W'(32'h0000010), W'(32'h0000100), W'(32'h0000020));
        finish_frame("f5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
